// File: rtl/spec_free_list_ckpt_pkg.sv
// Shared sizes, pointer types and pointer arithmetic for the speculative free list.
package free_list_pkg;

  localparam int PHYS_REGS = 96;
  localparam int ARCH_REGS = 32;
  localparam int ALLOC_W   = 4;
  localparam int FREE_W    = 4;
  localparam int N_CKPT    = 8;

  localparam int DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int TAG_W = $clog2(PHYS_REGS);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int CK_W  = $clog2(N_CKPT);

  // List pointer: the phase bit flips on every wrap so full and empty differ.
  typedef struct packed {
    logic             phase;
    logic [IDX_W-1:0] idx;
  } ptr_t;

  typedef logic [CK_W-1:0]  ckpt_id_t;
  typedef logic [CK_W:0]    qptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Advance a list pointer by n entries, wrapping DEPTH-1 -> 0 and toggling phase.
  function automatic ptr_t ptr_add(ptr_t p, cnt_t n);
    cnt_t sum;
    ptr_t r;
    sum     = {1'b0, p.idx} + n;
    r.phase = p.phase;
    r.idx   = IDX_W'(sum);
    if (sum >= CNT_W'(DEPTH)) begin
      r.phase = ~p.phase;
      r.idx   = IDX_W'(sum - CNT_W'(DEPTH));
    end
    return r;
  endfunction

endpackage

// File: rtl/spec_free_list_ckpt_if.sv
// Rename/retire side signals of the free list, bundled for one port.
interface spec_free_list_ckpt_if;
  import free_list_pkg::*;

  logic                     stall_i;
  logic [ALLOC_W-1:0]       alloc_req_i;
  logic                     alloc_ok_o;
  logic [ALLOC_W*TAG_W-1:0] alloc_tag_o;
  logic [FREE_W-1:0]        free_valid_i;
  logic [FREE_W*TAG_W-1:0]  free_tag_i;
  logic                     ckpt_req_i;
  ckpt_id_t                 ckpt_id_o;
  logic                     ckpt_full_o;
  logic                     ckpt_release_i;
  logic                     restore_i;
  ckpt_id_t                 restore_id_i;
  logic                     flush_i;
  cnt_t                     count_o;

  modport master (
    output stall_i, alloc_req_i, free_valid_i, free_tag_i, ckpt_req_i,
           ckpt_release_i, restore_i, restore_id_i, flush_i,
    input  alloc_ok_o, alloc_tag_o, ckpt_id_o, ckpt_full_o, count_o
  );

  modport slave (
    input  stall_i, alloc_req_i, free_valid_i, free_tag_i, ckpt_req_i,
           ckpt_release_i, restore_i, restore_id_i, flush_i,
    output alloc_ok_o, alloc_tag_o, ckpt_id_o, ckpt_full_o, count_o
  );

endinterface

// File: rtl/spec_free_list_ckpt_ram_nrnw.sv
// Free-list storage: ALLOC_W async read ports, FREE_W write ports, reset loads ARCH_REGS+i.
module free_list_ram_nrnw
  import free_list_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ALLOC_W*IDX_W-1:0] raddr,
  output logic [ALLOC_W*TAG_W-1:0] rdata,
  input  logic [FREE_W-1:0]        we,
  input  logic [FREE_W*IDX_W-1:0]  waddr,
  input  logic [FREE_W*TAG_W-1:0]  wdata
);

  logic [TAG_W-1:0] mem [DEPTH];

  // Reset fills the list with every non-architectural tag; otherwise write the
  // compacted frees (addresses never collide).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= TAG_W'(ARCH_REGS + i);
      end
    end else begin
      for (int k = 0; k < FREE_W; k++) begin
        if (we[k]) begin
          mem[waddr[k*IDX_W +: IDX_W]] <= wdata[k*TAG_W +: TAG_W];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ALLOC_W; gi++) begin : g_rd
      assign rdata[gi*TAG_W +: TAG_W] = mem[raddr[gi*IDX_W +: IDX_W]];
    end
  endgenerate

endmodule

// File: rtl/spec_free_list_ckpt.sv
// Speculative free list with a queue of saved head pointers for one-cycle mispredict recovery.
module spec_free_list_ckpt
  import free_list_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  spec_free_list_ckpt_if.slave bus
);

  ptr_t     head_reg, head_next, head_alloc, tail_reg, tail_next;
  qptr_t    qhead_reg, qhead_next, qtail_reg, qtail_next;
  ptr_t     saved_reg [N_CKPT];
  cnt_t     count, alloc_pop, free_pop, alloc_grant;
  cnt_t     alloc_ofs [ALLOC_W];
  cnt_t     free_ofs [FREE_W];
  ckpt_id_t restore_span;
  logic     alloc_ok, ckpt_full, ckpt_empty, ckpt_take;
  logic [ALLOC_W*IDX_W-1:0] raddr;
  logic [FREE_W*IDX_W-1:0]  waddr;
  logic [ALLOC_W*TAG_W-1:0] tags;

  // Free entries: tail minus head, with the phase bit telling full from empty.
  always_comb begin
    if (head_reg.phase == tail_reg.phase) begin
      count = {1'b0, tail_reg.idx} - {1'b0, head_reg.idx};
    end else begin
      count = CNT_W'(DEPTH) + {1'b0, tail_reg.idx} - {1'b0, head_reg.idx};
    end
  end

  // Per-lane prefix counts: offset of each lane among the requesting/valid lanes.
  always_comb begin
    alloc_pop = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      alloc_ofs[k] = alloc_pop;
      alloc_pop    = alloc_pop + cnt_t'(bus.alloc_req_i[k]);
    end
    free_pop = '0;
    for (int k = 0; k < FREE_W; k++) begin
      free_ofs[k] = free_pop;
      free_pop    = free_pop + cnt_t'(bus.free_valid_i[k]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ALLOC_W; gi++) begin : g_alloc
      ptr_t rd_ptr;
      assign rd_ptr = ptr_add(head_reg, alloc_ofs[gi]);
      assign raddr[gi*IDX_W +: IDX_W] = rd_ptr.idx;
    end
    for (gi = 0; gi < FREE_W; gi++) begin : g_free
      ptr_t wr_ptr;
      assign wr_ptr = ptr_add(tail_reg, free_ofs[gi]);
      assign waddr[gi*IDX_W +: IDX_W] = wr_ptr.idx;
    end
  endgenerate

  free_list_ram_nrnw u_ram (
    .clk   (clk),
    .reset (reset),
    .raddr (raddr),
    .rdata (tags),
    .we    (bus.free_valid_i),
    .waddr (waddr),
    .wdata (bus.free_tag_i)
  );

  assign ckpt_empty  = (qtail_reg == qhead_reg);
  assign ckpt_full   = ((qtail_reg - qhead_reg) == qptr_t'(N_CKPT));
  assign alloc_ok    = (count >= cnt_t'(ALLOC_W)) && !bus.stall_i && !bus.restore_i && !bus.flush_i;
  assign alloc_grant = alloc_ok ? alloc_pop : '0;
  assign ckpt_take   = bus.ckpt_req_i && alloc_ok && !ckpt_full;

  assign bus.alloc_ok_o  = alloc_ok;
  assign bus.alloc_tag_o = tags;
  assign bus.ckpt_id_o   = qtail_reg[CK_W-1:0];
  assign bus.ckpt_full_o = ckpt_full;
  assign bus.count_o     = count;

  // Pointer next state: flush beats restore beats allocate; tail only follows frees.
  always_comb begin
    head_alloc   = ptr_add(head_reg, alloc_grant);
    tail_next    = ptr_add(tail_reg, free_pop);
    qhead_next   = qhead_reg + qptr_t'(bus.ckpt_release_i);
    restore_span = bus.restore_id_i - qhead_next[CK_W-1:0];
    head_next    = head_alloc;
    qtail_next   = qtail_reg;
    if (bus.flush_i) begin
      head_next.phase = ~tail_next.phase;
      head_next.idx   = tail_next.idx;
      qtail_next      = qhead_next;
    end else if (bus.restore_i) begin
      head_next  = saved_reg[bus.restore_id_i];
      qtail_next = qhead_next + {1'b0, restore_span} + qptr_t'(1);
    end else if (ckpt_take) begin
      qtail_next = qtail_reg + qptr_t'(1);
    end
  end

  // Pointer registers; reset leaves the list full (tail phase set).
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg       <= '0;
      tail_reg.phase <= 1'b1;
      tail_reg.idx   <= '0;
      qhead_reg      <= '0;
      qtail_reg      <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      qhead_reg <= qhead_next;
      qtail_reg <= qtail_next;
    end
  end

  // Checkpoint slot captures the head as it stands after this cycle's allocation.
  always_ff @(posedge clk) begin
    if (!reset && ckpt_take) begin
      saved_reg[qtail_reg[CK_W-1:0]] <= head_alloc;
    end
  end

  // Protocol checks on the rename/retire side.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.ckpt_req_i && ckpt_full));
      assert (!(bus.ckpt_release_i && ckpt_empty));
      assert ((count - alloc_grant + free_pop) <= cnt_t'(DEPTH));
    end
  end

endmodule

// File: tb/tb_spec_free_list_ckpt.sv
// Directed vector bench for spec_free_list_ckpt: table of cycles plus a hand-written wrap sequence.
module tb_spec_free_list_ckpt;
  import free_list_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  spec_free_list_ckpt_if bus ();

  spec_free_list_ckpt dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic [3:0]  rq;
    logic [3:0]  fv;
    logic [27:0] ft;
    logic        ck;
    logic        rl;
    logic        rs;
    logic [2:0]  rid;
    logic        fl;
    logic        eok;
    int          ecnt;
    logic        efull;
    logic [2:0]  eid;
    logic [3:0]  tm;
    logic [27:0] et;
  } vec_t;

  vec_t vq[$];

  function automatic logic [27:0] pk(input int a, input int b, input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  function automatic vec_t mk(input int st, input int rq, input int fv, input logic [27:0] ft,
                              input int ck, input int rl, input int rs, input int rid, input int fl,
                              input int eok, input int ecnt, input int efull, input int eid,
                              input int tm, input logic [27:0] et);
    vec_t v;
    v.rst = 1'b0; v.st = 1'(st); v.rq = 4'(rq); v.fv = 4'(fv); v.ft = ft;
    v.ck = 1'(ck); v.rl = 1'(rl); v.rs = 1'(rs); v.rid = 3'(rid); v.fl = 1'(fl);
    v.eok = 1'(eok); v.ecnt = ecnt; v.efull = 1'(efull); v.eid = 3'(eid);
    v.tm = 4'(tm); v.et = et;
    return v;
  endfunction

  function automatic vec_t mk_rst();
    vec_t v;
    v = mk(0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    v.rst = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns later, commit on the rising edge.
  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    reset              = v.rst;
    bus.stall_i        = v.st;
    bus.alloc_req_i    = v.rq;
    bus.free_valid_i   = v.fv;
    bus.free_tag_i     = v.ft;
    bus.ckpt_req_i     = v.ck;
    bus.ckpt_release_i = v.rl;
    bus.restore_i      = v.rs;
    bus.restore_id_i   = v.rid;
    bus.flush_i        = v.fl;
    #1;
    if (!v.rst) begin
      check({nm, ".ok"}, int'(bus.alloc_ok_o), int'(v.eok));
      check({nm, ".count"}, int'(bus.count_o), v.ecnt);
      check({nm, ".full"}, int'(bus.ckpt_full_o), int'(v.efull));
      check({nm, ".id"}, int'(bus.ckpt_id_o), int'(v.eid));
      for (int k = 0; k < 4; k++) begin
        if (v.tm[k]) begin
          check($sformatf("%s.tag%0d", nm, k), int'(bus.alloc_tag_o[k*7 +: 7]), int'(v.et[k*7 +: 7]));
        end
      end
      $display("%s req=%b free=%b ok=%0d count=%0d id=%0d full=%0d tags=%0d,%0d,%0d,%0d", nm, v.rq, v.fv,
               bus.alloc_ok_o, bus.count_o, bus.ckpt_id_o, bus.ckpt_full_o, bus.alloc_tag_o[6:0],
               bus.alloc_tag_o[13:7], bus.alloc_tag_o[20:14], bus.alloc_tag_o[27:21]);
    end else begin
      $display("%s reset", nm);
    end
  endtask

  initial begin
    bus.stall_i = 0; bus.alloc_req_i = '0; bus.free_valid_i = '0; bus.free_tag_i = '0;
    bus.ckpt_req_i = 0; bus.ckpt_release_i = 0; bus.restore_i = 0; bus.restore_id_i = '0; bus.flush_i = 0;

    // Reset state, drain the list 4 at a time, then compacted frees at count 0.
    vq.push_back(mk_rst());
    vq.push_back(mk(0, 0, 0, '0, 0, 0, 0, 0, 0, 1, 64, 0, 0, 15, pk(32, 32, 32, 32)));
    for (int i = 0; i < 16; i++)
      vq.push_back(mk(0, 15, 0, '0, 0, 0, 0, 0, 0, 1, 64 - 4*i, 0, 0, 15, pk(32+4*i, 33+4*i, 34+4*i, 35+4*i)));
    vq.push_back(mk(0, 15, 0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
    vq.push_back(mk(0, 0, 10, pk(0, 40, 0, 41), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
    vq.push_back(mk(0, 15, 0, '0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 15, pk(40, 41, 34, 35)));

    // Sparse request mask: idle lanes still show a tag.
    vq.push_back(mk_rst());
    vq.push_back(mk(0, 10, 0, '0, 0, 0, 0, 0, 0, 1, 64, 0, 0, 15, pk(32, 32, 33, 33)));
    vq.push_back(mk(0, 0, 0, '0, 0, 0, 0, 0, 0, 1, 62, 0, 0, 15, pk(34, 34, 34, 34)));

    // Checkpoint after 8, allocate 8 more, restore with alloc+ckpt+free in the same cycle.
    vq.push_back(mk_rst());
    vq.push_back(mk(0, 15, 0, '0, 0, 0, 0, 0, 0, 1, 64, 0, 0, 15, pk(32, 33, 34, 35)));
    vq.push_back(mk(0, 15, 0, '0, 1, 0, 0, 0, 0, 1, 60, 0, 0, 15, pk(36, 37, 38, 39)));
    vq.push_back(mk(0, 15, 0, '0, 0, 0, 0, 0, 0, 1, 56, 0, 1, 15, pk(40, 41, 42, 43)));
    vq.push_back(mk(0, 15, 0, '0, 0, 0, 0, 0, 0, 1, 52, 0, 1, 15, pk(44, 45, 46, 47)));
    vq.push_back(mk(0, 15, 1, pk(44, 0, 0, 0), 1, 0, 1, 0, 0, 0, 48, 0, 1, 15, pk(48, 49, 50, 51)));
    vq.push_back(mk(0, 15, 0, '0, 1, 0, 0, 0, 0, 1, 57, 0, 1, 15, pk(40, 41, 42, 43)));
    vq.push_back(mk(0, 0, 0, '0, 0, 0, 0, 0, 0, 1, 53, 0, 2, 15, pk(44, 44, 44, 44)));

    // Fill all 8 slots, release one, wrap the id, restore id 3.
    vq.push_back(mk_rst());
    for (int k = 0; k < 8; k++)
      vq.push_back(mk(0, 1, 0, '0, 1, 0, 0, 0, 0, 1, 64 - k, 0, k, 1, pk(32 + k, 0, 0, 0)));
    vq.push_back(mk(0, 0, 0, '0, 0, 1, 0, 0, 0, 1, 56, 1, 0, 1, pk(40, 0, 0, 0)));
    vq.push_back(mk(0, 1, 0, '0, 1, 0, 0, 0, 0, 1, 56, 0, 0, 1, pk(40, 0, 0, 0)));
    vq.push_back(mk(0, 0, 0, '0, 0, 0, 1, 3, 0, 0, 55, 1, 1, 0, '0));
    vq.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 1, 60, 0, 4, 15, pk(36, 36, 36, 36)));
    vq.push_back(mk(0, 0, 0, '0, 0, 0, 0, 0, 0, 1, 60, 0, 5, 15, pk(36, 36, 36, 36)));

    // 40 allocations, a stalled cycle, then flush alongside two frees.
    vq.push_back(mk_rst());
    for (int i = 0; i < 10; i++)
      vq.push_back(mk(0, 15, 0, '0, 0, 0, 0, 0, 0, 1, 64 - 4*i, 0, 0, 15, pk(32+4*i, 33+4*i, 34+4*i, 35+4*i)));
    vq.push_back(mk(1, 15, 0, '0, 1, 0, 0, 0, 0, 0, 24, 0, 0, 0, '0));
    vq.push_back(mk(0, 15, 3, pk(33, 32, 0, 0), 0, 0, 0, 0, 1, 0, 24, 0, 0, 0, '0));
    vq.push_back(mk(0, 15, 0, '0, 0, 0, 0, 0, 0, 1, 64, 0, 0, 15, pk(34, 35, 36, 37)));
    vq.push_back(mk(0, 0, 0, '0, 0, 0, 0, 0, 0, 1, 60, 0, 0, 15, pk(38, 38, 38, 38)));

    for (int i = 0; i < vq.size(); i++) begin
      run_vec(vq[i], $sformatf("v%0d", i));
    end

    // Hand-written: last four tags go out while four are freed into entry 0; they come out
    // only on the following cycle, then the list is empty.
    run_vec(mk_rst(), "w.rst");
    for (int i = 0; i < 15; i++)
      run_vec(mk(0, 15, 0, '0, 0, 0, 0, 0, 0, 1, 64 - 4*i, 0, 0, 1, pk(32 + 4*i, 0, 0, 0)), $sformatf("w%0d", i));
    run_vec(mk(0, 15, 15, pk(50, 51, 52, 53), 0, 0, 0, 0, 0, 1, 4, 0, 0, 15, pk(92, 93, 94, 95)), "w.swap");
    run_vec(mk(0, 15, 0, '0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 15, pk(50, 51, 52, 53)), "w.reuse");
    run_vec(mk(0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0), "w.empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
